// File: rtl/thread_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler_pkg
// Description : Shared defaults for the barrel thread scheduler: thread count,
//               PC width and the reset PC layout of the per-thread PC table.
// Revision    : 1.0 - initial release
// ============================================================================
package thread_scheduler_pkg;

    // Default geometry of the scheduler.
    localparam int DEF_NUM_THREADS   = 8;
    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_BITS_THREADS  = $clog2(DEF_NUM_THREADS);

    // Reset PC layout: thread i starts at BASE + i * STRIDE.
    localparam logic [31:0] DEF_RESET_PC_BASE    = 32'h0000_0000;
    localparam logic [31:0] DEF_THREAD_PC_STRIDE = 32'h0000_0400;

    // Fixed instruction size used for the sequential PC advance.
    localparam int C_PC_INCREMENT = 4;

endpackage : thread_scheduler_pkg
`default_nettype wire

// File: rtl/thread_scheduler_rr_next_active.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler_rr_next_active
// Description : rr_next_active finder. Cyclic find-first-set over an active
//               mask, searching strictly after start_i and wrapping back to
//               start_i itself as the last candidate.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_scheduler_rr_next_active #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0]  mask_i,
    input  logic [BITS_THREADS-1:0] start_i,
    output logic [BITS_THREADS-1:0] next_o,
    output logic                    found_o
);

    logic [BITS_THREADS-1:0] idx;

    // Scan farthest candidate first so the nearest set bit is the last written.
    always_comb begin
        next_o  = start_i;
        found_o = 1'b0;
        idx     = start_i;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            // NUM_THREADS is a power of two, so truncation is the modulo wrap.
            idx = start_i + BITS_THREADS'(k);
            if (mask_i[idx]) begin
                next_o  = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule : thread_scheduler_rr_next_active
`default_nettype wire

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : thread_scheduler
// Description : Barrel-style hardware thread scheduler. Rotates an issue slot
//               over NUM_THREADS threads, keeps one PC per thread, supports
//               execute-stage redirects and thread start/halt.
//               Optional feature macro SCHED_SKIP_IDLE_EN: rotate only over
//               active threads instead of issuing bubbles for idle slots.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int                       NUM_THREADS       = DEF_NUM_THREADS,
    parameter int                       ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
    parameter int                       BITS_THREADS      = $clog2(NUM_THREADS),
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC_BASE     = ADDRESS_WIDTH'(DEF_RESET_PC_BASE),
    parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE  = ADDRESS_WIDTH'(DEF_THREAD_PC_STRIDE),
    parameter logic [NUM_THREADS-1:0]   RESET_ACTIVE_MASK = {NUM_THREADS{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    input  logic                     start_req,
    input  logic [BITS_THREADS-1:0]  start_tid,
    input  logic [ADDRESS_WIDTH-1:0] start_pc,
    input  logic                     halt_req,
    input  logic [BITS_THREADS-1:0]  halt_tid,
    output logic [ADDRESS_WIDTH-1:0] pc_s,
    output logic [BITS_THREADS-1:0]  tid_s,
    output logic                     valid_s,
    output logic [NUM_THREADS-1:0]   active_o
);

    logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0]   active_q;
    logic [NUM_THREADS-1:0]   active_d;
    logic [BITS_THREADS-1:0]  tid_q;
    logic [BITS_THREADS-1:0]  tid_d;
    logic [BITS_THREADS-1:0]  tid_adv;
    logic                     issue;

    // Issue slot is a pure read of the current registers.
    assign tid_s    = tid_q;
    assign pc_s     = pc_q[tid_q];
    assign valid_s  = active_q[tid_q];
    assign active_o = active_q;
    assign issue    = valid_s & ~stall;

`ifdef SCHED_SKIP_IDLE_EN
    logic [BITS_THREADS-1:0] rr_next;
    logic                    rr_found;

    // Search uses the registered mask; same-cycle start/halt is not seen.
    thread_scheduler_rr_next_active #(
        .NUM_THREADS  (NUM_THREADS),
        .BITS_THREADS (BITS_THREADS)
    ) u_rr_next_active (
        .mask_i  (active_q),
        .start_i (tid_q),
        .next_o  (rr_next),
        .found_o (rr_found)
    );

    assign tid_adv = rr_found ? rr_next : tid_q + BITS_THREADS'(1);
`else
    // Strict barrel timing: every slot is visited, idle ones as bubbles.
    assign tid_adv = tid_q + BITS_THREADS'(1);
`endif

    // Next-state: writes applied lowest priority first so later ones win.
    always_comb begin
        pc_d     = pc_q;
        active_d = active_q;
        tid_d    = stall ? tid_q : tid_adv;

        if (issue) begin
            pc_d[tid_q] = pc_q[tid_q] + ADDRESS_WIDTH'(C_PC_INCREMENT);
        end
        if (pc_src_e) begin
            pc_d[tid_e] = pc_target_e;
        end
        if (start_req) begin
            pc_d[start_tid] = start_pc;
        end

        if (halt_req) begin
            active_d[halt_tid] = 1'b0;
        end
        if (start_req) begin
            active_d[start_tid] = 1'b1;
        end
    end

    // State registers; reset lays out the PC table and drops any pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tid_q    <= '0;
            active_q <= RESET_ACTIVE_MASK;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= RESET_PC_BASE + ADDRESS_WIDTH'(i) * THREAD_PC_STRIDE;
            end
        end else begin
            tid_q    <= tid_d;
            active_q <= active_d;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

endmodule : thread_scheduler
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_thread_scheduler
// Description : Directed self-checking bench for thread_scheduler with the
//               default 8-thread, 32-bit configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [2:0]  tid_e;
    logic        start_req;
    logic [2:0]  start_tid;
    logic [31:0] start_pc;
    logic        halt_req;
    logic [2:0]  halt_tid;
    logic [31:0] pc_s;
    logic [2:0]  tid_s;
    logic        valid_s;
    logic [7:0]  active_o;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    thread_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .tid_e       (tid_e),
        .start_req   (start_req),
        .start_tid   (start_tid),
        .start_pc    (start_pc),
        .halt_req    (halt_req),
        .halt_tid    (halt_tid),
        .pc_s        (pc_s),
        .tid_s       (tid_s),
        .valid_s     (valid_s),
        .active_o    (active_o)
    );

    always #5 clk = ~clk;

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = '0;
        tid_e       = '0;
        start_req   = 1'b0;
        start_tid   = '0;
        start_pc    = '0;
        halt_req    = 1'b0;
        halt_tid    = '0;
        step(2);
        rst = 1'b0;

        // ---------------- reset state ----------------
        chk("reset_tid",    32'(tid_s),    32'd0);
        chk("reset_pc",     pc_s,          32'h0);
        chk("reset_valid",  32'(valid_s),  32'd1);
        chk("reset_active", 32'(active_o), 32'hFF);

        // ---------------- free-running rotation, 10 cycles ----------------
        for (int c = 0; c < 10; c++) begin
            chk("rot_tid",   32'(tid_s),   32'(c % 8));
            chk("rot_pc",    pc_s,         (c < 8) ? 32'(c) * 32'h400 : 32'(c - 8) * 32'h400 + 32'h4);
            chk("rot_valid", 32'(valid_s), 32'd1);
            step(1);
        end

        // ---------------- redirect thread 3 while slot 0 issues ----------------
        do_reset();
        pc_src_e = 1'b1; tid_e = 3'd3; pc_target_e = 32'h2000;
        step(1);
        pc_src_e = 1'b0;
        step(2);
        chk("redir_tid", 32'(tid_s), 32'd3);
        chk("redir_pc",  pc_s,       32'h2000);
        step(1);
        // Redirect to the slot issuing this cycle must beat its +4 increment.
        chk("redir_prio_tid", 32'(tid_s), 32'd4);
        pc_src_e = 1'b1; tid_e = 3'd4; pc_target_e = 32'h5000;
        step(1);
        pc_src_e = 1'b0;
        step(7);
        chk("redir_prio_pc", pc_s, 32'h5000);

        // ---------------- halt thread 2 ----------------
        do_reset();
        halt_req = 1'b1; halt_tid = 3'd2;
        step(1);
        halt_req = 1'b0;
        chk("halt_active", 32'(active_o), 32'hFB);
`ifdef SCHED_SKIP_IDLE_EN
        chk("halt_tid1", 32'(tid_s), 32'd1);
        step(1);
        chk("halt_skip_tid", 32'(tid_s), 32'd3);
        chk("halt_skip_vld", 32'(valid_s), 32'd1);
`else
        step(1);
        chk("halt_bubble_tid", 32'(tid_s),   32'd2);
        chk("halt_bubble_vld", 32'(valid_s), 32'd0);
        chk("halt_bubble_pc",  pc_s,         32'h800);
        step(8);
        chk("halt_frozen_vld", 32'(valid_s), 32'd0);
        chk("halt_frozen_pc",  pc_s,         32'h800);
        step(1);
        chk("halt_next_tid", 32'(tid_s),   32'd3);
        chk("halt_next_vld", 32'(valid_s), 32'd1);
`endif

        // ---------------- halt the thread being issued ----------------
        do_reset();
        halt_req = 1'b1; halt_tid = 3'd0;
        step(1);
        halt_req = 1'b0;
        chk("halt_self_active", 32'(active_o), 32'hFE);
        step(7);
`ifdef SCHED_SKIP_IDLE_EN
        chk("halt_self_tid", 32'(tid_s), 32'd1);
`else
        chk("halt_self_tid", 32'(tid_s),   32'd0);
        chk("halt_self_vld", 32'(valid_s), 32'd0);
        chk("halt_self_pc",  pc_s,         32'h4);
`endif

        // ---------------- start and halt same tid: start wins ----------------
        do_reset();
        halt_req = 1'b1; halt_tid = 3'd5;
        step(1);
        chk("pre_halt5_active", 32'(active_o), 32'hDF);
        start_req = 1'b1; start_tid = 3'd5; start_pc = 32'h3000;
        step(1);
        start_req = 1'b0; halt_req = 1'b0;
        chk("start_win_active", 32'(active_o), 32'hFF);
        step(3);
        chk("start_tid", 32'(tid_s),   32'd5);
        chk("start_pc",  pc_s,         32'h3000);
        chk("start_vld", 32'(valid_s), 32'd1);

        // ---------------- stall at slot 4 ----------------
        do_reset();
        step(4);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("stall_tid", 32'(tid_s), 32'd4);
            chk("stall_pc",  pc_s,       32'h1000);
            step(1);
        end
        stall = 1'b0;
        chk("stall_rel_tid", 32'(tid_s), 32'd4);
        chk("stall_rel_pc",  pc_s,       32'h1000);
        step(1);
        chk("resume_tid", 32'(tid_s), 32'd5);
        chk("resume_pc",  pc_s,       32'h1400);
        step(7);
        chk("stall_once_pc", pc_s, 32'h1004);

        // ---------------- PC wrap on thread 6 ----------------
        do_reset();
        pc_src_e = 1'b1; tid_e = 3'd6; pc_target_e = 32'hFFFF_FFFC;
        step(1);
        pc_src_e = 1'b0;
        step(5);
        chk("wrap_pre_tid", 32'(tid_s), 32'd6);
        chk("wrap_pre_pc",  pc_s,       32'hFFFF_FFFC);
        step(8);
        chk("wrap_post_pc", pc_s, 32'h0);

        // ---------------- reset mid-run ignores other inputs ----------------
        rst = 1'b1;
        pc_src_e = 1'b1; tid_e = 3'd1; pc_target_e = 32'hDEAD;
        halt_req = 1'b1; halt_tid = 3'd3;
        step(1);
        rst = 1'b0; pc_src_e = 1'b0; halt_req = 1'b0;
        chk("midrst_tid",    32'(tid_s),    32'd0);
        chk("midrst_pc",     pc_s,          32'h0);
        chk("midrst_active", 32'(active_o), 32'hFF);
        step(1);
        chk("midrst_pc1", pc_s, 32'h400);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_thread_scheduler
`default_nettype wire
